// File: rtl/sum_acc_pkg.sv
// Shared types and default sizing for the frame sum accumulator.
package sum_acc_pkg;

    localparam int unsigned ACC_W_DEF = 16;
    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned IN_W      = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage : sum_acc_pkg

// File: rtl/sum_accumulator.sv
// Accumulates 9-bit sum beats into a per-frame total, beat count and sticky
// overflow flag, then holds the result until the downstream side takes it.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sum,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow
);

    localparam int unsigned SUM_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    logic [SUM_W-1:0] sum_c;
    logic [CNT_W-1:0] count_nxt_c;
    logic             xfer_c;

    // Extra top bit of the sum captures the carry out of the accumulator.
    assign sum_c       = {1'b0, out_acc} + SUM_W'(in_sum);
    assign count_nxt_c = out_count + CNT_W'(1);
    assign xfer_c      = in_valid && in_ready;

    // The result registers double as the running accumulator; they read 0 in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            out_acc      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
            out_valid    <= 1'b0;
            in_ready     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer_c) begin
                        out_acc      <= ACC_W'(in_sum);
                        out_count    <= CNT_W'(1);
                        out_overflow <= 1'b0;
                        if (in_last) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (xfer_c) begin
                        out_acc      <= sum_c[ACC_W-1:0];
                        out_count    <= count_nxt_c;
                        out_overflow <= out_overflow | sum_c[ACC_W];
                        // A full beat counter closes the frame regardless of in_last.
                        if (in_last || (count_nxt_c == CNT_MAX)) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state        <= IDLE;
                        out_valid    <= 1'b0;
                        in_ready     <= 1'b1;
                        out_acc      <= '0;
                        out_count    <= '0;
                        out_overflow <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    out_valid    <= 1'b0;
                    in_ready     <= 1'b1;
                    out_acc      <= '0;
                    out_count    <= '0;
                    out_overflow <= 1'b0;
                end
            endcase
        end
    end

endmodule : sum_accumulator

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: a frame-level model is compared against
// the DUT every cycle, with literal expectations on the headline scenarios.
module tb_sum_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_sum;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_acc;
    logic [7:0]  out_count;
    logic        out_overflow;

    int n_checks;
    int n_err;

    // Model: 0 = waiting for a frame, 1 = inside a frame, 2 = result pending.
    int     m_phase;
    longint m_total;
    int     m_count;

    sum_accumulator #(.ACC_W(16), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sum       (in_sum),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_acc      (out_acc),
        .out_count    (out_count),
        .out_overflow (out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame model: true (unwrapped) total and beat count of the current frame.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_total = 0;
            m_count = 0;
        end else if (m_phase == 2) begin
            if (out_ready) begin
                m_phase = 0;
                m_total = 0;
                m_count = 0;
            end
        end else if (in_valid) begin
            if (m_phase == 0) begin
                m_total = 0;
                m_count = 0;
            end
            m_total = m_total + longint'(in_sum);
            m_count = m_count + 1;
            m_phase = (in_last || m_count == 255) ? 2 : 1;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("m_in_ready", longint'(in_ready), (m_phase != 2) ? 1 : 0);
        chk("m_out_valid", longint'(out_valid), (m_phase == 2) ? 1 : 0);
        if (m_phase == 2) begin
            chk("m_out_acc", longint'(out_acc), m_total % 65536);
            chk("m_out_count", longint'(out_count), longint'(m_count));
            chk("m_out_overflow", longint'(out_overflow), (m_total > 65535) ? 1 : 0);
        end else if (m_phase == 0) begin
            chk("m_idle_acc", longint'(out_acc), 0);
            chk("m_idle_count", longint'(out_count), 0);
            chk("m_idle_overflow", longint'(out_overflow), 0);
        end
    endtask

    // Drive one cycle of inputs (just after a falling edge), then check at the next falling edge.
    task automatic cyc(input logic v, input logic [8:0] s, input logic l, input logic r);
        in_valid  = v;
        in_sum    = s;
        in_last   = l;
        out_ready = r;
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        n_checks  = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_acc", longint'(out_acc), 0);
        chk("rst_out_count", longint'(out_count), 0);
        rst_n = 1'b1;
        cyc(1'b0, 9'd0, 1'b0, 1'b0);
        chk("rst_in_ready", longint'(in_ready), 1);

        // Single beat frame with one-cycle latency.
        cyc(1'b1, 9'h1FE, 1'b1, 1'b0);
        chk("one_valid", longint'(out_valid), 1);
        chk("one_acc", longint'(out_acc), 64'h01FE);
        chk("one_count", longint'(out_count), 1);
        chk("one_ovf", longint'(out_overflow), 0);
        cyc(1'b0, 9'd0, 1'b0, 1'b1);
        chk("one_release", longint'(out_valid), 0);

        // Three beats, downstream always ready.
        cyc(1'b1, 9'd100, 1'b0, 1'b1);
        cyc(1'b1, 9'd200, 1'b0, 1'b1);
        cyc(1'b1, 9'd300, 1'b1, 1'b1);
        chk("three_valid", longint'(out_valid), 1);
        chk("three_acc", longint'(out_acc), 64'h0258);
        chk("three_count", longint'(out_count), 3);
        cyc(1'b0, 9'd0, 1'b0, 1'b1);
        chk("three_one_cycle", longint'(out_valid), 0);

        // Beats with idle gaps inside the frame.
        cyc(1'b1, 9'd10, 1'b0, 1'b0);
        cyc(1'b0, 9'd77, 1'b1, 1'b0);
        cyc(1'b0, 9'd77, 1'b1, 1'b0);
        cyc(1'b1, 9'd20, 1'b1, 1'b0);
        chk("gap_acc", longint'(out_acc), 30);
        chk("gap_count", longint'(out_count), 2);
        cyc(1'b0, 9'd0, 1'b0, 1'b1);

        // Backpressure: HOLD for 5 cycles while upstream keeps offering beats.
        cyc(1'b1, 9'd7, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 9'd9, 1'b1, 1'b0);
            chk("bp_in_ready", longint'(in_ready), 0);
            chk("bp_acc_stable", longint'(out_acc), 7);
            chk("bp_count_stable", longint'(out_count), 1);
        end
        cyc(1'b1, 9'd9, 1'b1, 1'b1);
        chk("bp_back_idle", longint'(in_ready), 1);
        cyc(1'b1, 9'd9, 1'b1, 1'b0);
        chk("bp_next_frame_acc", longint'(out_acc), 9);
        chk("bp_next_frame_count", longint'(out_count), 1);
        cyc(1'b0, 9'd0, 1'b0, 1'b1);

        // Saturation close after 255 beats of the maximum value.
        for (int i = 0; i < 255; i++) begin
            cyc(1'b1, 9'h1FF, 1'b0, 1'b0);
            if (i == 253) chk("sat_not_yet", longint'(in_ready), 1);
        end
        chk("sat_valid", longint'(out_valid), 1);
        chk("sat_count", longint'(out_count), 255);
        chk("sat_acc", longint'(out_acc), 64'hFD01);
        chk("sat_ovf", longint'(out_overflow), 1);
        cyc(1'b0, 9'd0, 1'b0, 1'b1);

        // Overflow flag is cleared by the next frame.
        cyc(1'b1, 9'd1, 1'b1, 1'b0);
        chk("ovf_cleared", longint'(out_overflow), 0);
        cyc(1'b0, 9'd0, 1'b0, 1'b1);

        // Reset in the middle of a frame discards it.
        cyc(1'b1, 9'd3, 1'b0, 1'b1);
        cyc(1'b1, 9'd3, 1'b0, 1'b1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_acc", longint'(out_acc), 0);
        chk("mid_rst_count", longint'(out_count), 0);
        chk("mid_rst_valid", longint'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 9'd0, 1'b0, 1'b1);
        cyc(1'b1, 9'h005, 1'b1, 1'b1);
        chk("post_rst_acc", longint'(out_acc), 5);
        chk("post_rst_count", longint'(out_count), 1);
        cyc(1'b0, 9'd0, 1'b0, 1'b1);

        // Reset while a result is pending: no output transfer survives.
        cyc(1'b1, 9'd50, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("hold_rst_valid", longint'(out_valid), 0);
        chk("hold_rst_ready", longint'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 9'd0, 1'b0, 1'b1);
        cyc(1'b0, 9'd0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_sum_accumulator
